// File: rtl/npu_pkg.sv
// Shared types and register map for the NPU host interface.
// Included by the host slave and its testbench.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    DONE    = 2'd2
  } host_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  localparam int STAT_FULL  = 16;
  localparam int STAT_EMPTY = 17;
  localparam int STAT_DONE  = 18;
  localparam int STAT_OVF   = 19;
  localparam int STAT_STATE = 20;

  // 224 image + 18816 conv + 16746 dense
  localparam int TOTAL_WORDS_DEF = 35786;

endpackage

// File: rtl/npu_host_if_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and level output.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the level gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/npu_host_if.sv
// Avalon-MM slave feeding host DATA words to the NPU loader through a FIFO.
// Tracks delivered words and raises done once the full payload is streamed.
module npu_host_if
  import npu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int TOTAL_WORDS = TOTAL_WORDS_DEF,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [31:0] control_reg,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(TOTAL_WORDS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL_WORDS - 1);

  host_state_t      state_q, state_d;
  logic [31:0]      control_q, control_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             ctrl_wr, data_wr, rd_en;
  logic             clear, start, drop;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      status;

  assign ctrl_wr = chipselect & write & (address == ADDR_CTRL);
  assign data_wr = chipselect & write & (address == ADDR_DATA);
  assign rd_en   = chipselect & read;
  assign clear   = ctrl_wr & writedata[CTRL_CLEAR];
  assign start   = ctrl_wr & writedata[CTRL_START];

  // DONE swallows data writes rather than stalling a host nobody drains.
  assign drop        = data_wr & (state_q == DONE);
  assign push        = data_wr & ~fifo_full & (state_q != DONE);
  assign waitrequest = data_wr & fifo_full & (state_q != DONE);
  assign out_valid   = (state_q == LOADING) & ~fifo_empty;
  assign pop         = out_valid & out_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .din   (writedata),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    status = '0;
    status[CNT_W-1:0]      = CNT_W'(fifo_level);
    status[STAT_FULL]      = fifo_full;
    status[STAT_EMPTY]     = fifo_empty;
    status[STAT_DONE]      = done_q;
    status[STAT_OVF]       = ovf_q;
    status[STAT_STATE +: 2] = state_q;
  end

  always_comb begin
    control_d = control_q;
    control_d[CTRL_CLEAR] = 1'b0;
    if (ctrl_wr) control_d = writedata;

    count_d = count_q;
    if (pop && count_q != TOTAL) count_d = count_q + CNT_W'(1);

    ovf_d   = ovf_q | drop;
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOADING;
      LOADING: if (pop && count_q == LAST) state_d = DONE;
      DONE:    if (ctrl_wr && !writedata[CTRL_START]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      ovf_d   = 1'b0;
    end
    done_d = (state_d == DONE);

    readdata_d = readdata_q;
    if (rd_en) begin
      unique case (address)
        ADDR_CTRL:   readdata_d = control_q;
        ADDR_DATA:   readdata_d = '0;
        ADDR_STATUS: readdata_d = status;
        ADDR_COUNT:  readdata_d = 32'(count_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      control_q  <= '0;
      readdata_q <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      control_q  <= control_d;
      readdata_q <= readdata_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign readdata    = readdata_q;
  assign control_reg = control_q;
  assign done        = done_q;

endmodule

// File: tb/tb_npu_host_if.sv
// Directed bench for npu_host_if with a short payload (TOTAL_WORDS=8).
// Register table first, then multi-cycle load, stall, clear and reset cases.
module tb_npu_host_if;
  import npu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address = '0;
  logic [31:0] writedata = '0;
  logic        out_ready = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic [31:0] control_reg;
  logic [31:0] out_data;
  logic        out_valid;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [31:0] popped[$];

  npu_host_if #(
    .FIFO_DEPTH  (16),
    .TOTAL_WORDS (8),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .control_reg (control_reg),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_IDLE = 2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    #1;
    if (out_valid && out_ready) popped.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    chipselect = 1'b1;
    write = 1'b1;
    address = a;
    writedata = d;
    #1;
    while (waitrequest && n < 50) begin
      tick();
      n++;
    end
    chk("wr_wait", 32'(waitrequest), 32'd0);
    tick();
    chipselect = 1'b0;
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read = 1'b1;
    address = a;
    tick();
    chipselect = 1'b0;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic rdchk(input string nm, input logic [1:0] a,
                       input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(nm, v, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt[13];
    logic [31:0] v;
    int n;

    vt[0]  = '{OP_RD,   ADDR_CTRL,   32'h0,         32'h0};
    vt[1]  = '{OP_RD,   ADDR_COUNT,  32'h0,         32'h0};
    vt[2]  = '{OP_RD,   ADDR_DATA,   32'h0,         32'h0};
    vt[3]  = '{OP_WR,   ADDR_CTRL,   32'h0000_0100, 32'h0};
    vt[4]  = '{OP_RD,   ADDR_CTRL,   32'h0,         32'h0000_0100};
    vt[5]  = '{OP_RD,   ADDR_STATUS, 32'h0,         32'h0002_0000};
    vt[6]  = '{OP_WR,   ADDR_DATA,   32'hDEAD_BEEF, 32'h0};
    vt[7]  = '{OP_RD,   ADDR_STATUS, 32'h0,         32'h0000_0001};
    vt[8]  = '{OP_RD,   ADDR_DATA,   32'h0,         32'h0};
    vt[9]  = '{OP_WR,   ADDR_CTRL,   32'h0000_0102, 32'h0};
    vt[10] = '{OP_IDLE, ADDR_CTRL,   32'h0,         32'h0};
    vt[11] = '{OP_RD,   ADDR_CTRL,   32'h0,         32'h0000_0100};
    vt[12] = '{OP_RD,   ADDR_STATUS, 32'h0,         32'h0002_0000};

    // reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_control", control_reg, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_waitreq", 32'(waitrequest), 32'h0);
    reset = 1'b0;
    tick();
    rdchk("rst_status", ADDR_STATUS, 32'h0002_0000);

    for (int i = 0; i < 13; i++) begin
      case (vt[i].op)
        OP_RD:   rdchk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
        OP_WR:   wr(vt[i].addr, vt[i].data);
        default: tick();
      endcase
    end

    // preload in IDLE, then start
    out_ready = 1'b1;
    wr(ADDR_DATA, 32'hA1B2_C3D4);
    wr(ADDR_DATA, 32'h0102_0304);
    chk("pre_valid", 32'(out_valid), 32'h0);
    rdchk("pre_level", ADDR_STATUS, 32'h0000_0002);
    popped.delete();
    wr(ADDR_CTRL, 32'h1);
    chk("pre_head0", out_data, 32'hA1B2_C3D4);
    tick();
    chk("pre_head1", out_data, 32'h0102_0304);
    tick();
    chk("pre_npop", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("pre_pop0", popped[0], 32'hA1B2_C3D4);
      chk("pre_pop1", popped[1], 32'h0102_0304);
    end
    rdchk("pre_count", ADDR_COUNT, 32'd2);

    // backpressure: 17 writes into 16 entries
    out_ready = 1'b0;
    wr(ADDR_CTRL, 32'h2);
    wr(ADDR_CTRL, 32'h1);
    popped.delete();
    for (int i = 0; i < 16; i++) wr(ADDR_DATA, 32'h100 + 32'(i));
    rdchk("bp_status", ADDR_STATUS, 32'h0011_0010);
    chipselect = 1'b1;
    write = 1'b1;
    address = ADDR_DATA;
    writedata = 32'h110;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall", 32'(waitrequest), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_stall_pop", 32'(waitrequest), 32'h1);
    tick();
    chk("bp_release", 32'(waitrequest), 32'h0);
    tick();
    chipselect = 1'b0;
    write = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("bp_done", 32'(done), 32'h1);
    chk("bp_npop8", 32'(popped.size()), 32'd8);
    wr(ADDR_CTRL, 32'h0);
    wr(ADDR_CTRL, 32'h1);
    repeat (12) tick();
    chk("bp_npop17", 32'(popped.size()), 32'd17);
    if (popped.size() == 17)
      for (int i = 0; i < 17; i++)
        chk($sformatf("bp_order%0d", i), popped[i], 32'h100 + 32'(i));
    rdchk("bp_count_sat", ADDR_COUNT, 32'd8);

    // completion of an 8-word load
    wr(ADDR_CTRL, 32'h2);
    wr(ADDR_CTRL, 32'h1);
    popped.delete();
    for (int i = 0; i < 8; i++) wr(ADDR_DATA, 32'h200 + 32'(i));
    chk("cmp_npop7", 32'(popped.size()), 32'd7);
    chk("cmp_not_done", 32'(done), 32'h0);
    tick();
    chk("cmp_npop8", 32'(popped.size()), 32'd8);
    chk("cmp_done", 32'(done), 32'h1);
    chk("cmp_valid", 32'(out_valid), 32'h0);
    rdchk("cmp_count", ADDR_COUNT, 32'd8);
    wr(ADDR_DATA, 32'h999);
    rdchk("cmp_status", ADDR_STATUS, 32'h002E_0000);

    // CLEAR after 5 of 8 words
    wr(ADDR_CTRL, 32'h2);
    wr(ADDR_CTRL, 32'h1);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(ADDR_DATA, 32'h300 + 32'(i));
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    rdchk("clr_count5", ADDR_COUNT, 32'd5);
    wr(ADDR_CTRL, 32'h3);
    chk("clr_ctrl3", control_reg, 32'h3);
    chk("clr_valid", 32'(out_valid), 32'h0);
    tick();
    chk("clr_ctrl1", control_reg, 32'h1);
    rdchk("clr_status", ADDR_STATUS, 32'h0002_0000);
    rdchk("clr_count0", ADDR_COUNT, 32'd0);

    // asynchronous reset between edges
    wr(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) wr(ADDR_DATA, 32'h400 + 32'(i));
    rd(ADDR_CTRL, v);
    chk("ar_pre_rd", v, 32'h1);
    chk("ar_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    #2;
    chk("ar_readdata", readdata, 32'h0);
    chk("ar_control", control_reg, 32'h0);
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
    #1;
    reset = 1'b0;
    tick();
    rdchk("ar_status", ADDR_STATUS, 32'h0002_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
